// File: rtl/sprite_grabber.sv
// Sprite grabber: snapshots a 16x16 one-bit region of the live pixel stream into
// sprite bitmap RAM, writing each captured row as a low byte then a high byte.
module sprite_grabber #(
  parameter int unsigned BMP_BITS = 3,
  parameter int unsigned CNT_BITS = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arm,
  input  logic                abort,
  input  logic [BMP_BITS-1:0] bmp_sel,
  input  logic                hmirror,
  input  logic                vmirror,
  input  logic                vstart,
  input  logic                hstart,
  input  logic                pix,
  output logic [BMP_BITS+4:0] wr_addr,
  output logic [7:0]          wr_data,
  output logic                wr_en,
  output logic                busy,
  output logic                done,
  output logic [CNT_BITS-1:0] pix_count
);

  typedef enum logic [2:0] {
    StIdle, StWaitV, StWaitH, StCapture, StStoreLo, StStoreHi
  } state_e;

  state_e              state_q, state_d;
  logic [BMP_BITS-1:0] bmp_q, bmp_d;
  logic                hmir_q, hmir_d;
  logic                vmir_q, vmir_d;
  logic [3:0]          row_q, row_d;
  logic [3:0]          col_q, col_d;
  logic [15:0]         shift_q, shift_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_BITS-1:0] pc_q, pc_d;
  logic [BMP_BITS+4:0] addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                wr_en_q, wr_en_d;
  logic                done_q, done_d;
  logic [3:0]          vm_row;
  logic [3:0]          bit_idx;

  assign vm_row  = vmir_q ? ~row_q : row_q;
  assign bit_idx = hmir_q ? (4'd15 - col_q) : col_q;

  always_comb begin
    state_d = state_q;
    bmp_d   = bmp_q;
    hmir_d  = hmir_q;
    vmir_d  = vmir_q;
    row_d   = row_q;
    col_d   = col_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (arm) begin
          bmp_d   = bmp_sel;
          hmir_d  = hmirror;
          vmir_d  = vmirror;
          row_d   = '0;
          col_d   = '0;
          shift_d = '0;
          cnt_d   = '0;
          state_d = StWaitV;
        end
      end
      StWaitV: begin
        if (vstart) begin
          col_d   = '0;
          state_d = hstart ? StCapture : StWaitH;
        end
      end
      StWaitH: begin
        if (hstart) begin
          col_d   = '0;
          state_d = StCapture;
        end
      end
      StCapture: begin
        shift_d[bit_idx] = pix;
        cnt_d = cnt_q + CNT_BITS'(pix);
        col_d = col_q + 4'd1;
        if (col_q == 4'd15) state_d = StStoreLo;
      end
      StStoreLo: begin
        wr_en_d = 1'b1;
        addr_d  = {bmp_q, vm_row, 1'b0};
        data_d  = shift_q[7:0];
        state_d = StStoreHi;
      end
      StStoreHi: begin
        wr_en_d = 1'b1;
        addr_d  = {bmp_q, vm_row, 1'b1};
        data_d  = shift_q[15:8];
        if (row_q == 4'd15) begin
          pc_d    = cnt_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          row_d   = row_q + 4'd1;
          shift_d = '0;
          state_d = StWaitH;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything: drop any pending write and skip the done pulse.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      wr_en_d = 1'b0;
      done_d  = 1'b0;
      pc_d    = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      bmp_q   <= '0;
      hmir_q  <= 1'b0;
      vmir_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bmp_q   <= bmp_d;
      hmir_q  <= hmir_d;
      vmir_q  <= vmir_d;
      row_q   <= row_d;
      col_q   <= col_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
    end
  end

  assign wr_addr   = addr_q;
  assign wr_data   = data_q;
  assign wr_en     = wr_en_q;
  assign done      = done_q;
  assign pix_count = pc_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_sprite_grabber.sv
// Bench for sprite_grabber: drives whole-frame captures from a 16x16 image table and
// compares the resulting bitmap RAM and pixel count against an image-level model.
module tb_sprite_grabber;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] bmp_sel = '0;
  logic       hmirror = 1'b0;
  logic       vmirror = 1'b0;
  logic       vstart = 1'b0;
  logic       hstart = 1'b0;
  logic       pix = 1'b0;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       busy;
  logic       done;
  logic [8:0] pix_count;

  int checks = 0;
  int errors = 0;
  int nwrites = 0;
  int ndone = 0;

  logic [7:0] ram     [256];
  logic [7:0] exp_ram [256];
  logic       img     [16][16];
  logic [2:0] cur_bmp;
  logic       cur_hm;
  logic       cur_vm;
  logic [8:0] exp_pc;

  sprite_grabber #(.BMP_BITS(3), .CNT_BITS(9)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .bmp_sel(bmp_sel),
    .hmirror(hmirror), .vmirror(vmirror), .vstart(vstart), .hstart(hstart), .pix(pix),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy), .done(done),
    .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  // Bitmap RAM stand-in plus done/busy exclusivity.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      ram[wr_addr] = wr_data;
      nwrites++;
    end
    if (done === 1'b1) begin
      ndone++;
      checks++;
      assert (busy === 1'b0) else begin
        errors++;
        $error("FAIL busy_at_done: observed %0b expected 0", busy);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic make_img(input int kind);
    int density;
    density = $urandom_range(10, 90);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        case (kind)
          0: img[r][c] = (c % 2 == 0);
          1: img[r][c] = (r == 0 && c == 0);
          2: img[r][c] = (r == 0);
          3: img[r][c] = 1'b1;
          default: img[r][c] = ($urandom_range(0, 99) < density);
        endcase
  endtask

  // Row r of the image lands at row (vm ? 15-r : r); pixel x at bit (hm ? 15-x : x).
  task automatic model_rows(input int nrows);
    for (int r = 0; r < nrows; r++) begin
      logic [15:0] w;
      int sr;
      int base;
      w = '0;
      for (int x = 0; x < 16; x++)
        if (img[r][x]) w[cur_hm ? 15 - x : x] = 1'b1;
      sr = cur_vm ? 15 - r : r;
      base = int'(cur_bmp) * 32 + sr * 2;
      exp_ram[base]     = w[7:0];
      exp_ram[base + 1] = w[15:8];
    end
  endtask

  function automatic logic [8:0] count_img();
    int n = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        n += int'(img[r][c]);
    return 9'(n);
  endfunction

  task automatic check_ram(input string tag);
    for (int a = 0; a < 256; a++)
      check($sformatf("%s_ram[%02h]", tag, a), 32'(ram[a]), 32'(exp_ram[a]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check({tag, "_wr_data"}, 32'(wr_data), 0);
    check({tag, "_pix_count"}, 32'(pix_count), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // mode 0: full capture; 1: abort once row stop_row is stored; 2: extra arm in row 1,
  // then reset in the middle of row stop_row.
  task automatic drive_frame(input int mode, input int stop_row);
    bit together;
    @(negedge clk);
    bmp_sel = cur_bmp; hmirror = cur_hm; vmirror = cur_vm; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    bmp_sel = 3'($urandom); hmirror = 1'($urandom); vmirror = 1'($urandom);
    hstart = 1'b1;  // stray line start before the frame start must be ignored
    @(negedge clk);
    hstart = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    together = 1'($urandom);
    for (int r = 0; r < 16; r++) begin
      if (r == 0) begin
        if (together) begin
          vstart = 1'b1; hstart = 1'b1;
          @(negedge clk);
        end else begin
          vstart = 1'b1;
          @(negedge clk);
          vstart = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          hstart = 1'b1;
          @(negedge clk);
        end
      end else begin
        hstart = 1'b0; vstart = 1'b0;
        repeat (2 + $urandom_range(0, 3)) begin
          pix = 1'($urandom);
          @(negedge clk);
        end
        if (mode == 1 && r - 1 == stop_row) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          check("busy_after_abort", 32'(busy), 0);
          return;
        end
        hstart = 1'b1;
        @(negedge clk);
      end
      for (int c = 0; c < 16; c++) begin
        pix = img[r][c];
        hstart = 1'b0; vstart = 1'b0; arm = 1'b0;
        if (c == 8) begin
          hstart = 1'($urandom); vstart = 1'($urandom);
        end
        if (mode == 2 && r == 1 && c == 3) begin
          arm = 1'b1; bmp_sel = ~cur_bmp; hmirror = ~cur_hm; vmirror = ~cur_vm;
        end
        if (mode == 2 && r == stop_row && c == 7) begin
          reset = 1'b0;
          #1;
          check_reset_outputs("midreset");
          @(negedge clk);
          reset = 1'b1;
          return;
        end
        @(negedge clk);
      end
    end
    hstart = 1'b0; vstart = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_full(input string tag);
    nwrites = 0; ndone = 0;
    drive_frame(0, -1);
    model_rows(16);
    exp_pc = count_img();
    check({tag, "_writes"}, 32'(nwrites), 32);
    check({tag, "_done_pulses"}, 32'(ndone), 1);
    check({tag, "_pix_count"}, 32'(pix_count), 32'(exp_pc));
    check({tag, "_busy_idle"}, 32'(busy), 0);
    check_ram(tag);
  endtask

  task automatic randomize_cfg();
    cur_bmp = 3'($urandom); cur_hm = 1'($urandom); cur_vm = 1'($urandom);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      ram[a] = '0;
      exp_ram[a] = '0;
    end
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    cur_bmp = 3'd2; cur_hm = 1'b0; cur_vm = 1'b0;
    make_img(0);
    run_full("even_cols");
    check("even_cols_first_byte", 32'(ram[8'h40]), 32'h55);
    check("even_cols_last_byte", 32'(ram[8'h5F]), 32'h55);
    check("even_cols_count", 32'(pix_count), 128);

    cur_bmp = 3'd2; cur_hm = 1'b1; cur_vm = 1'b0;
    make_img(1);
    run_full("hmirror");
    check("hmirror_hi_byte", 32'(ram[8'h41]), 32'h80);
    check("hmirror_lo_byte", 32'(ram[8'h40]), 32'h00);
    check("hmirror_count", 32'(pix_count), 1);

    cur_bmp = 3'($urandom); cur_hm = 1'b0; cur_vm = 1'b1;
    make_img(2);
    run_full("vmirror");
    check("vmirror_count", 32'(pix_count), 16);

    randomize_cfg();
    make_img(3);
    run_full("all_set");
    check("all_set_count", 32'(pix_count), 256);

    for (int i = 0; i < 4; i++) begin
      randomize_cfg();
      make_img(4);
      run_full($sformatf("rand%0d", i));
    end

    randomize_cfg();
    make_img(4);
    nwrites = 0; ndone = 0;
    drive_frame(1, 5);
    repeat (5) @(negedge clk);
    model_rows(6);
    check("abort_writes", 32'(nwrites), 12);
    check("abort_done_pulses", 32'(ndone), 0);
    check("abort_pix_count", 32'(pix_count), 32'(exp_pc));
    check("abort_busy", 32'(busy), 0);
    check_ram("abort");

    randomize_cfg();
    make_img(4);
    run_full("rearm");

    randomize_cfg();
    make_img(4);
    nwrites = 0; ndone = 0;
    drive_frame(2, 3);
    model_rows(3);
    exp_pc = '0;
    check("reset_frame_writes", 32'(nwrites), 6);
    check("reset_frame_done", 32'(ndone), 0);
    nwrites = 0;
    for (int i = 0; i < 40; i++) begin
      pix = 1'($urandom);
      hstart = (i % 7 == 0);
      vstart = (i == 3);
      @(negedge clk);
    end
    hstart = 1'b0; vstart = 1'b0;
    check("post_reset_writes", 32'(nwrites), 0);
    check("post_reset_done", 32'(ndone), 0);
    check("post_reset_busy", 32'(busy), 0);
    check("post_reset_pix_count", 32'(pix_count), 0);
    check_ram("reset_frame");

    randomize_cfg();
    make_img(4);
    run_full("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
